// File: rtl/fft_pkg.sv
// Shared types for the FFT butterfly datapath: coefficient word layout and
// the control states of the runtime-loadable coefficient table.
package fft_pkg;

  localparam int CW = 11;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } coeff_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/coeff_ram_sp.sv
// Synchronous-write, registered-read coefficient array. Kept free of reset on
// the storage so it maps onto distributed or block RAM.
module coeff_ram_sp #(
  parameter int SIZE = 32,
  parameter int W    = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [$clog2(SIZE)-1:0] waddr_i,
  input  logic [W-1:0]            wdata_i,
  input  logic                    re_i,
  input  logic [$clog2(SIZE)-1:0] raddr_i,
  output logic [W-1:0]            rdata_o
);

  logic [W-1:0] mem_q [SIZE];
  logic [W-1:0] rdata_q;

  // NOTE: the array has no reset branch; resetting it would block RAM inference
  // and its contents are only trusted after a complete load anyway.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The output register holds while re_i is low, which gives the stream its
  // stall behaviour for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/coeff_mem_loader.sv
// Runtime-loadable twiddle table: SIZE words written over valid/ready, then
// streamed cyclically to the butterfly multiplier one word per enabled cycle.
module coeff_mem_loader
  import fft_pkg::*;
#(
  parameter  int SIZE = 32,
  parameter  int CW   = fft_pkg::CW,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2*CW-1:0] wr_data,
  output logic            load_done,
  input  logic            stream_en,
  output logic [2*CW-1:0] coeff_out,
  output logic            coeff_valid,
  output logic [AW-1:0]   coeff_idx
);

  state_t        state_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic          wr_ready_q;
  logic          load_done_q;
  logic          coeff_valid_q;
  logic [AW-1:0] coeff_idx_q;

  logic wr_fire;
  logic rd_fire;
  logic last_word;

  // wr_ready_q is high exactly while in LOAD, so this also gates writes by state.
  assign wr_fire   = wr_valid && wr_ready_q;
  assign rd_fire   = (state_q == STREAM) && stream_en && !load_start;
  assign last_word = (wptr_q == AW'(SIZE - 1));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      wr_ready_q    <= 1'b0;
      load_done_q   <= 1'b0;
      coeff_valid_q <= 1'b0;
      coeff_idx_q   <= '0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q    <= LOAD;
            wptr_q     <= '0;
            wr_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          // A restart beats the final word: it is written but not counted.
          if (load_start) begin
            wptr_q <= '0;
          end else if (wr_fire) begin
            wptr_q <= wptr_q + 1'b1;
            if (last_word) begin
              state_q     <= STREAM;
              rptr_q      <= '0;
              wr_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (load_start) begin
            state_q       <= LOAD;
            wptr_q        <= '0;
            wr_ready_q    <= 1'b1;
            coeff_valid_q <= 1'b0;
          end else if (stream_en) begin
            coeff_idx_q   <= rptr_q;
            coeff_valid_q <= 1'b1;
            rptr_q        <= rptr_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  coeff_ram_sp #(
    .SIZE (SIZE),
    .W    (2 * CW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_fire),
    .waddr_i (wptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_fire),
    .raddr_i (rptr_q),
    .rdata_o (coeff_out)
  );

  assign wr_ready    = wr_ready_q;
  assign load_done   = load_done_q;
  assign coeff_valid = coeff_valid_q;
  assign coeff_idx   = coeff_idx_q;

endmodule

// File: tb/tb_coeff_mem_loader.sv
// Self-checking bench for coeff_mem_loader: a vector table for control
// behaviour, plus a scoreboard of expected stream words for the data path.
module tb_coeff_mem_loader;

  localparam int SIZE = 32;
  localparam int CW   = 11;
  localparam int AW   = 5;
  localparam int DW   = 2 * CW;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          load_done;
  logic          stream_en;
  logic [DW-1:0] coeff_out;
  logic          coeff_valid;
  logic [AW-1:0] coeff_idx;

  coeff_mem_loader #(.SIZE(SIZE), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .load_done   (load_done),
    .stream_en   (stream_en),
    .coeff_out   (coeff_out),
    .coeff_valid (coeff_valid),
    .coeff_idx   (coeff_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          ls;
    logic          wv;
    logic [DW-1:0] wd;
    logic          se;
    logic          exp_ready;
    logic          exp_done;
    logic          exp_valid;
  } vec_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb_q[$];
  sb_t           last_out;
  logic [DW-1:0] exp_mem [SIZE];
  logic [AW-1:0] exp_r;
  int            done_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int kind, input int i);
    logic [DW-1:0] w;
    case (kind)
      0:       w = DW'(i * 32'h1001);
      1:       w = DW'(32'h3FFFFF - i);
      default: w = DW'((i * 32'h421) ^ 32'h15555);
    endcase
    return w;
  endfunction

  // Called at a falling edge; drives inputs and returns at the next falling
  // edge, so outputs are sampled half a cycle after the active edge.
  task automatic tick(input logic ls, input logic wv, input logic [DW-1:0] wd, input logic se);
    load_start = ls;
    wr_valid   = wv;
    wr_data    = wd;
    stream_en  = se;
    @(negedge clk);
    if (load_done === 1'b1) done_count++;
  endtask

  // Writes all SIZE words (assumes LOAD already entered); optional idle gaps.
  task automatic load_table(input int kind, input bit gaps);
    logic [DW-1:0] w;
    done_count = 0;
    for (int i = 0; i < SIZE; i++) begin
      w = pattern(kind, i);
      exp_mem[i] = w;
      if (gaps && (i % 2 == 1)) begin
        tick(1'b0, 1'b0, ~w, 1'b0);
        check("gap_ready", 32'(wr_ready), 32'd1);
      end
      tick(1'b0, 1'b1, w, 1'b0);
      check("load_done", 32'(load_done), 32'(i == SIZE - 1));
      check("load_ready", 32'(wr_ready), 32'(i != SIZE - 1));
      check("load_valid", 32'(coeff_valid), 32'd0);
    end
    check("done_once", 32'(done_count), 32'd1);
    exp_r = '0;
  endtask

  task automatic stream(input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = exp_r;
      e.data = exp_mem[exp_r];
      sb_q.push_back(e);
      exp_r = exp_r + 1'b1;
      tick(1'b0, 1'b0, '0, 1'b1);
      e = sb_q.pop_front();
      check("stream_valid", 32'(coeff_valid), 32'd1);
      check("stream_idx", 32'(coeff_idx), 32'(e.idx));
      check("stream_data", 32'(coeff_out), 32'(e.data));
      last_out = e;
    end
  endtask

  task automatic stall(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 1'b1, 22'h3A5A5, 1'b0);
      check("stall_valid", 32'(coeff_valid), 32'd1);
      check("stall_idx", 32'(coeff_idx), 32'(last_out.idx));
      check("stall_data", 32'(coeff_out), 32'(last_out.data));
      check("stall_ready", 32'(wr_ready), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    vecs[0] = '{ls: 1'b0, wv: 1'b1, wd: 22'h2AAAA, se: 1'b1, exp_ready: 1'b0, exp_done: 1'b0, exp_valid: 1'b0};
    vecs[1] = '{ls: 1'b0, wv: 1'b0, wd: 22'h00000, se: 1'b1, exp_ready: 1'b0, exp_done: 1'b0, exp_valid: 1'b0};
    vecs[2] = '{ls: 1'b1, wv: 1'b1, wd: 22'h15555, se: 1'b1, exp_ready: 1'b1, exp_done: 1'b0, exp_valid: 1'b0};
    vecs[3] = '{ls: 1'b0, wv: 1'b0, wd: 22'h00000, se: 1'b1, exp_ready: 1'b1, exp_done: 1'b0, exp_valid: 1'b0};
    vecs[4] = '{ls: 1'b1, wv: 1'b1, wd: 22'h0F0F0, se: 1'b0, exp_ready: 1'b1, exp_done: 1'b0, exp_valid: 1'b0};

    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    stream_en  = 1'b0;
    exp_r      = '0;
    done_count = 0;
    last_out   = '{idx: '0, data: '0};
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_valid", 32'(coeff_valid), 32'd0);
    check("rst_out", 32'(coeff_out), 32'd0);
    check("rst_idx", 32'(coeff_idx), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores writes and stream enables; load_start (re)enters LOAD at 0.
    for (int v = 0; v < 5; v++) begin
      tick(vecs[v].ls, vecs[v].wv, vecs[v].wd, vecs[v].se);
      check("vec_ready", 32'(wr_ready), 32'(vecs[v].exp_ready));
      check("vec_done", 32'(load_done), 32'(vecs[v].exp_done));
      check("vec_valid", 32'(coeff_valid), 32'(vecs[v].exp_valid));
      check("vec_idx", 32'(coeff_idx), 32'd0);
    end

    // Full load, then stream with stream_en high from the STREAM entry cycle.
    load_table(0, 1'b0);
    stream(70);

    // Stall at idx 7, resume at 8, run on to idx 12 and abort there.
    stream(2);
    check("pre_stall_idx", 32'(coeff_idx), 32'd7);
    stall(3);
    stream(5);
    check("pre_abort_idx", 32'(coeff_idx), 32'd12);
    tick(1'b1, 1'b1, 22'h12345, 1'b1);
    check("abort_valid", 32'(coeff_valid), 32'd0);
    check("abort_ready", 32'(wr_ready), 32'd1);
    check("abort_done", 32'(load_done), 32'd0);

    // Reload with idle gaps between words; new values stream from idx 0.
    load_table(1, 1'b1);
    stream(33);

    // load_start coincident with the final word: no done pulse, restart at 0.
    tick(1'b1, 1'b0, '0, 1'b0);
    check("coll_enter_ready", 32'(wr_ready), 32'd1);
    done_count = 0;
    for (int i = 0; i < SIZE - 1; i++) tick(1'b0, 1'b1, pattern(0, i), 1'b0);
    tick(1'b1, 1'b1, pattern(0, SIZE - 1), 1'b0);
    check("coll_done", 32'(load_done), 32'd0);
    check("coll_ready", 32'(wr_ready), 32'd1);
    check("coll_valid", 32'(coeff_valid), 32'd0);
    repeat (3) begin
      tick(1'b0, 1'b0, '0, 1'b1);
      check("coll_wait_valid", 32'(coeff_valid), 32'd0);
    end
    check("coll_no_done", 32'(done_count), 32'd0);
    load_table(2, 1'b0);
    stream(32);

    // Asynchronous reset mid-load after 10 words.
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, pattern(1, i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(wr_ready), 32'd0);
    check("arst_valid", 32'(coeff_valid), 32'd0);
    check("arst_out", 32'(coeff_out), 32'd0);
    check("arst_idx", 32'(coeff_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      tick(1'b0, 1'b1, 22'h2BCDE, 1'b1);
      check("post_rst_valid", 32'(coeff_valid), 32'd0);
      check("post_rst_ready", 32'(wr_ready), 32'd0);
    end
    tick(1'b1, 1'b0, '0, 1'b1);
    check("post_rst_load", 32'(wr_ready), 32'd1);
    load_table(0, 1'b0);
    stream(5);

    tick(1'b0, 1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
